// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with registered single-cycle ops and a multi-cycle signed restoring divider owning HI/LO.
// Define ALU_DIV_FAST_EN to finish trivial divides (divisor 0 or |a|<|b|) at the accept edge.
module alu_exec #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             undef_op
);
  localparam logic [3:0] ALU_NOP     = 4'd0;
  localparam logic [3:0] ALU_ADD     = 4'd1;
  localparam logic [3:0] ALU_SUB     = 4'd2;
  localparam logic [3:0] ALU_AND     = 4'd3;
  localparam logic [3:0] ALU_OR      = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRA     = 4'd6;
  localparam logic [3:0] ALU_SLLI    = 4'd7;
  localparam logic [3:0] ALU_RS_PASS = 4'd8;
  localparam logic [3:0] ALU_SLT     = 4'd9;
  localparam logic [3:0] ALU_DIV     = 4'd10;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIV_RUN = 2'd1;
  localparam logic [1:0] DIV_FIX = 2'd2;
  logic [1:0]       state;
  logic [4:0]       count;
  logic [WIDTH-1:0] q, r, dvs, a_hold;
  logic             neg_q, neg_r, div0;
  logic [WIDTH-1:0] alu_res, abs_a, abs_b, qf, rf;
  logic             alu_undef, fast;
  logic [WIDTH:0]   t, d;
  assign in_ready = state == IDLE;
  assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign t  = {r, q[WIDTH-1]};
  assign d  = t - {1'b0, dvs};
  assign qf = neg_q ? -q : q;
  assign rf = neg_r ? -r : r;
`ifdef ALU_DIV_FAST_EN
  assign fast = operand_b == '0 || abs_a < abs_b;
`else
  assign fast = 1'b0;
`endif
  always_comb begin
    alu_res   = '0;
    alu_undef = 1'b0;
    case (alu_op)
      ALU_NOP, ALU_DIV: alu_res = '0;
      ALU_ADD:     alu_res = operand_a + operand_b;
      ALU_SUB:     alu_res = operand_a - operand_b;
      ALU_AND:     alu_res = operand_a & operand_b;
      ALU_OR:      alu_res = operand_a | operand_b;
      ALU_SLL:     alu_res = operand_b << shamt;
      ALU_SRA:     alu_res = $signed(operand_b) >>> shamt;
      ALU_SLLI:    alu_res = operand_b << 16;
      ALU_RS_PASS: alu_res = operand_a;
      ALU_SLT:     alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      default:     alu_undef = 1'b1;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      q         <= '0;
      r         <= '0;
      dvs       <= '0;
      a_hold    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      undef_op  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      undef_op  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      undef_op  <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (alu_op != ALU_DIV) begin
            result    <= alu_res;
            out_valid <= 1'b1;
            undef_op  <= alu_undef;
          end else if (fast) begin
            lo        <= operand_b == '0 ? '1 : '0;
            result    <= operand_b == '0 ? '1 : '0;
            hi        <= operand_a;
            out_valid <= 1'b1;
          end else begin
            q      <= abs_a;
            r      <= '0;
            dvs    <= abs_b;
            a_hold <= operand_a;
            neg_q  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            neg_r  <= operand_a[WIDTH-1];
            div0   <= operand_b == '0;
            count  <= '0;
            state  <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          r     <= d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
          q     <= {q[WIDTH-2:0], ~d[WIDTH]};
          count <= count + 5'd1;
          if (count == 5'(DIV_ITERS - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo        <= div0 ? '1 : qf;
          result    <= div0 ? '1 : qf;
          hi        <= div0 ? a_hold : rf;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
module tb_alu_exec;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
    ALU_OR = 4'd4, ALU_SLL = 4'd5, ALU_SRA = 4'd6, ALU_SLLI = 4'd7, ALU_RS_PASS = 4'd8,
    ALU_SLT = 4'd9, ALU_DIV = 4'd10, ALU_UNDEF = 4'd15;
  logic clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic in_ready, out_valid, undef_op;
  logic [3:0] alu_op = '0;
  logic [31:0] operand_a = '0, operand_b = '0, result, hi, lo;
  logic [4:0] shamt = '0;
  int passed = 0, total = 0;
  always #5 clock = ~clock;
  alu_exec dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .hi(hi), .lo(lo), .undef_op(undef_op)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    in_valid = 1'b1; alu_op = op; operand_a = a; operand_b = b; shamt = sh;
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
  endtask
  task automatic test_reset();
    total++; if ({out_valid, undef_op, in_ready} !== 3'b001) $display("FAIL reset_flags got %b want 001", {out_valid, undef_op, in_ready}); else passed++;
    total++; if ({result, hi, lo} !== 96'd0) $display("FAIL reset_regs got %h want 0", {result, hi, lo}); else passed++;
    reset = 1'b0;
    step();
  endtask
  task automatic test_back_to_back();
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
    total++; if ({out_valid, in_ready, result} !== {2'b11, 32'd0}) $display("FAIL b2b_add got %b%b %h want 11 00000000", out_valid, in_ready, result); else passed++;
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
    total++; if ({out_valid, in_ready, result} !== {2'b11, 32'd1}) $display("FAIL b2b_slt got %b%b %h want 11 00000001", out_valid, in_ready, result); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", out_valid); else passed++;
  endtask
  task automatic test_ops();
    logic [3:0] ops [8] = '{ALU_SRA, ALU_SLLI, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_RS_PASS, ALU_NOP};
    logic [31:0] as [8] = '{0, 0, 5, 32'hF0F0, 32'hF0F0, 0, 32'hDEAD_BEEF, 7};
    logic [31:0] bs [8] = '{32'h8000_0000, 32'h1234, 7, 32'hFF00, 32'hFF00, 1, 3, 9};
    logic [4:0]  ss [8] = '{4, 0, 0, 0, 0, 31, 0, 0};
    logic [31:0] ex [8] = '{32'hF800_0000, 32'h1234_0000, 32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'h8000_0000, 32'hDEAD_BEEF, 0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], ss[i]);
      total++; if ({out_valid, undef_op, result} !== {2'b10, ex[i]}) $display("FAIL op%0d got %b%b %h want 10 %h", i, out_valid, undef_op, result, ex[i]); else passed++;
    end
    total++; if ({hi, lo} !== 64'd0) $display("FAIL ops_hilo got %h want 0", {hi, lo}); else passed++;
  endtask
  task automatic test_div();
    int lat;
    int busy = 0;
    issue(ALU_DIV, -32'sd7, 32'd2, 5'd0);
    while (!out_valid && busy < 40) begin
      if (busy == 5) begin in_valid = 1'b1; alu_op = ALU_ADD; operand_a = 1; operand_b = 1; end
      if (in_ready) break;
      step();
      in_valid = 1'b0;
      busy++;
    end
    lat = busy;
    total++; if (lat !== 33) $display("FAIL div_latency got %0d want 33", lat); else passed++;
    total++; if ({out_valid, in_ready} !== 2'b11) $display("FAIL div_done got %b%b want 11", out_valid, in_ready); else passed++;
    total++; if ({lo, hi, result} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2 got %h %h %h want fffffffd ffffffff fffffffd", lo, hi, result); else passed++;
    step();
    total++; if ({out_valid, result} !== {1'b0, 32'hFFFF_FFFD}) $display("FAIL div_pulse got %b %h want 0 fffffffd", out_valid, result); else passed++;
  endtask
  task automatic test_div_bounds();
    int lat;
    issue(ALU_DIV, 32'd5, 32'd0, 5'd0);
    wait_done(lat);
`ifdef ALU_DIV_FAST_EN
    total++; if (lat !== 0) $display("FAIL div0_latency got %0d want 0", lat); else passed++;
`else
    total++; if (lat !== 33) $display("FAIL div0_latency got %0d want 33", lat); else passed++;
`endif
    total++; if ({lo, hi} !== {32'hFFFF_FFFF, 32'd5}) $display("FAIL div0 got %h %h want ffffffff 00000005", lo, hi); else passed++;
    step();
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_done(lat);
    total++; if ({lat, lo, hi} !== {32'd33, 32'h8000_0000, 32'd0}) $display("FAIL div_ovf got %0d %h %h want 33 80000000 00000000", lat, lo, hi); else passed++;
    step();
    issue(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 5'd0);
    wait_done(lat);
    total++; if ({lo, hi} !== {32'hFFFF_FFF2, 32'd2}) $display("FAIL div_100_m7 got %h %h want fffffff2 00000002", lo, hi); else passed++;
    step();
  endtask
  task automatic test_flush();
    int seen = 0;
    issue(ALU_DIV, 32'd1000, 32'd3, 5'd0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if ({out_valid, in_ready, lo, hi} !== {2'b01, 32'hFFFF_FFF2, 32'd2}) $display("FAIL flush got %b%b %h %h want 01 fffffff2 00000002", out_valid, in_ready, lo, hi); else passed++;
    repeat (40) begin step(); if (out_valid) seen++; end
    total++; if (seen !== 0) $display("FAIL flush_discard got %0d pulses want 0", seen); else passed++;
    flush = 1'b1;
    issue(ALU_ADD, 32'd2, 32'd3, 5'd0);
    flush = 1'b0;
    total++; if ({out_valid, result} !== {1'b0, 32'hFFFF_FFF2}) $display("FAIL flush_wins got %b %h want 0 fffffff2", out_valid, result); else passed++;
  endtask
  task automatic test_undef();
    issue(ALU_UNDEF, 32'd4, 32'd4, 5'd0);
    total++; if ({out_valid, undef_op, result} !== {2'b11, 32'd0}) $display("FAIL undef got %b%b %h want 11 00000000", out_valid, undef_op, result); else passed++;
    issue(4'd12, 32'd4, 32'd4, 5'd0);
    total++; if ({out_valid, undef_op, result} !== {2'b11, 32'd0}) $display("FAIL unmapped got %b%b %h want 11 00000000", out_valid, undef_op, result); else passed++;
    step();
    total++; if (undef_op !== 1'b0) $display("FAIL undef_pulse got %b want 0", undef_op); else passed++;
  endtask
  task automatic test_reset_mid_divide();
    issue(ALU_DIV, 32'd50, 32'd7, 5'd0);
    repeat (5) step();
    total++; if (in_ready !== 1'b0) $display("FAIL busy_before_reset got %b want 0", in_ready); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if ({out_valid, in_ready, result, hi, lo} !== {2'b01, 96'd0}) $display("FAIL reset_mid got %b%b %h %h %h want 01 0 0 0", out_valid, in_ready, result, hi, lo); else passed++;
    step();
    reset = 1'b0;
    step();
    total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL reset_release got %b%b want 01", out_valid, in_ready); else passed++;
  endtask
  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_ops();
    test_div();
    test_div_bounds();
    test_flush();
    test_undef();
    test_reset_mid_divide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
